// File: rtl/mmh_accumulator.sv
// mmh_accumulator: sums a stream of products mod P and emits one hash word per block.
// Define MMH_LAST_EN to add in_last, which closes a block early.
module mmh_accumulator #(
  parameter int DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] MODULUS = 64'hFFFFFFFF00000001,
  parameter int BLOCK_LEN = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
`ifdef MMH_LAST_EN
  input  logic                  in_last,
`endif
  output logic                  in_ready,
  output logic                  hash_valid,
  output logic [DATA_WIDTH-1:0] hash_data,
  input  logic                  hash_ready,
  output logic [CNT_WIDTH-1:0]  blk_cnt
);
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [DATA_WIDTH-1:0] acc, x, acc_next;
  logic [DATA_WIDTH:0] s;
  logic [15:0] cnt;
  logic accept, handoff, close;
  assign in_ready = (state != DONE) || hash_ready;
  assign accept = in_valid && in_ready;
  assign handoff = (state == DONE) && hash_ready;
  assign x = in_data >= MODULUS ? in_data - MODULUS : in_data;
  assign s = {1'b0, acc} + {1'b0, x};
  assign acc_next = DATA_WIDTH'(s >= {1'b0, MODULUS} ? s - {1'b0, MODULUS} : s);
`ifdef MMH_LAST_EN
  assign close = (cnt == 16'(BLOCK_LEN - 1)) || in_last;
`else
  assign close = cnt == 16'(BLOCK_LEN - 1);
`endif
  // acc and cnt are zero outside ACCUM, so a first word sums onto zero uniformly
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      hash_valid <= 1'b0;
      hash_data <= '0;
      blk_cnt <= '0;
    end else begin
      if (handoff) begin
        hash_valid <= 1'b0;
        blk_cnt <= CNT_WIDTH'(blk_cnt + 1'b1);
        state <= IDLE;
      end
      if (accept) begin
        if (close) begin
          hash_data <= acc_next;
          hash_valid <= 1'b1;
          acc <= '0;
          cnt <= '0;
          state <= DONE;
        end else begin
          acc <= acc_next;
          cnt <= cnt + 16'd1;
          state <= ACCUM;
        end
      end
    end
  end
endmodule

// File: tb/tb_mmh_accumulator.sv
// tb_mmh_accumulator: directed and random checks of mmh_accumulator against a sum-mod-P model.
module tb_mmh_accumulator;
  localparam logic [63:0] P = 64'hFFFFFFFF00000001;
  localparam int BL = 4;
`ifdef MMH_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, hash_ready = 0;
  logic [63:0] in_data = '0;
  logic in_ready, hash_valid;
  logic [63:0] hash_data;
  logic [15:0] blk_cnt;
  int total = 0, bad = 0;
  logic [63:0] cur[$];
  logic m_valid = 0;
  logic [63:0] m_hash = '0;
  logic [15:0] m_blk = '0;

  mmh_accumulator #(.BLOCK_LEN(BL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
`ifdef MMH_LAST_EN
    .in_last(in_last),
`endif
    .in_ready(in_ready), .hash_valid(hash_valid), .hash_data(hash_data),
    .hash_ready(hash_ready), .blk_cnt(blk_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [63:0] d, input bit hr, input bit l);
    bit acc, ho;
    logic [127:0] sum;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; hash_ready = hr; in_last = l;
    #1;
    chk("in_ready", 64'(in_ready), 64'(!m_valid || hr));
    acc = !r && v && in_ready;
    ho = !r && m_valid && hr;
    @(posedge clk);
    #1;
    if (r) begin
      cur.delete(); m_valid = 0; m_hash = '0; m_blk = '0;
    end else begin
      if (ho) begin m_valid = 0; m_blk++; end
      if (acc) begin
        cur.push_back(d);
        if (cur.size() == BL || (LAST_EN && l)) begin
          sum = '0;
          foreach (cur[i]) sum += 128'(cur[i]);
          m_hash = 64'(sum % 128'(P));
          m_valid = 1;
          cur.delete();
        end
      end
    end
    chk("hash_valid", 64'(hash_valid), 64'(m_valid));
    chk("blk_cnt", 64'(blk_cnt), 64'(m_blk));
    if (m_valid) chk("hash_data", hash_data, m_hash);
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_hash_data", hash_data, 64'd0);
    chk("rst_hash_valid", 64'(hash_valid), 64'd0);
    chk("rst_blk_cnt", 64'(blk_cnt), 64'd0);
    for (int i = 1; i <= 4; i++) step(0, 1, 64'(i), 1, 0);
    chk("sum10", hash_data, 64'd10);
    step(0, 0, 0, 1, 0);
    chk("blk1", 64'(blk_cnt), 64'd1);
    for (int i = 0; i < 4; i++) step(0, 1, 64'hFFFFFFFF00000000, 1, 0);
    chk("wrap", hash_data, 64'hFFFFFFFEFFFFFFFD);
    step(0, 1, 64'hFFFFFFFFFFFFFFFF, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 64'd0, 1, 0);
    chk("noncanon", hash_data, 64'h00000000FFFFFFFE);
    step(0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, 64'(i), 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 64'd7, 0, 0);
      chk("bp_hold", hash_data, 64'd10);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 64'd7, 1, 0);
    chk("bp_sum28", hash_data, 64'd28);
    step(0, 0, 0, 1, 0);
    step(0, 1, 64'd9, 1, 0);
    step(0, 1, 64'd9, 1, 0);
    step(1, 0, 0, 1, 0);
    chk("midrst_valid", 64'(hash_valid), 64'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 64'd1, 1, 0);
    chk("midrst_sum", hash_data, 64'd4);
    step(0, 0, 0, 1, 0);
    chk("midrst_blk", 64'(blk_cnt), 64'd1);
`ifdef MMH_LAST_EN
    step(0, 1, 64'd5, 1, 0);
    step(0, 1, 64'd6, 1, 1);
    chk("last11", hash_data, 64'd11);
    for (int i = 0; i < 4; i++) step(0, 1, 64'd1, 1, 0);
    chk("last_restart", hash_data, 64'd4);
    step(0, 1, 64'd42, 1, 1);
    chk("last_first", hash_data, 64'd42);
`endif
    for (int i = 0; i < 400; i++)
      step(0, ($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 3) != 0, ($urandom % 8) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
